// File: rtl/cache_arbiter_if.sv
// Line-side request/response signals for both caches plus the shared memory line port.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface cache_arbiter_if #(
    parameter int s_line = 256,
    parameter int s_addr = 32
);
    logic              i_read;
    logic              i_write;
    logic [s_addr-1:0] i_address;
    logic [s_line-1:0] i_wdata;
    logic [s_line-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [s_addr-1:0] d_address;
    logic [s_line-1:0] d_wdata;
    logic [s_line-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [s_addr-1:0] mem_address;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_write, i_address, i_wdata,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_write, i_address, i_wdata,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one memory line port between I-cache and D-cache; ties alternate starting with I.
// Memory op one cycle after the request; requesters hold until resp, which follows mem_resp combinationally.
module cache_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_d;
    logic              last_d_nxt;
    logic              grant_i;
    logic              grant_d;
    logic              i_pend;
    logic              d_pend;
    logic              req_read;
    logic              req_write;
    logic [s_addr-1:0] lat_address;
    logic [s_line-1:0] lat_wdata;

    assign i_pend = bus.i_read | bus.i_write;
    assign d_pend = bus.d_read | bus.d_write;

    // last_d records the most recent grant, so a tie goes to whichever side was not just served.
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_pend && (!d_pend || last_d)) begin
                    grant_i    = 1'b1;
                    state_nxt  = SERVE_I;
                    last_d_nxt = 1'b0;
                end else if (d_pend) begin
                    grant_d    = 1'b1;
                    state_nxt  = SERVE_D;
                    last_d_nxt = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    // Write wins if a requester illegally raises read and write together.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_read    <= 1'b0;
            req_write   <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
        end else if (grant_i) begin
            req_read    <= bus.i_read & ~bus.i_write;
            req_write   <= bus.i_write;
            lat_address <= bus.i_address;
            lat_wdata   <= bus.i_wdata;
        end else if (grant_d) begin
            req_read    <= bus.d_read & ~bus.d_write;
            req_write   <= bus.d_write;
            lat_address <= bus.d_address;
            lat_wdata   <= bus.d_wdata;
        end else if ((state != IDLE) && bus.mem_resp) begin
            req_read    <= 1'b0;
            req_write   <= 1'b0;
        end
    end

    assign bus.mem_read    = req_read;
    assign bus.mem_write   = req_write;
    assign bus.mem_address = lat_address;
    assign bus.mem_wdata   = lat_wdata;

    assign bus.i_resp  = (state == SERVE_I) & bus.mem_resp;
    assign bus.d_resp  = (state == SERVE_D) & bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed scenarios followed by randomized cache/memory traffic checked against a transaction-level model.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_arbiter_if #(.s_line(LW), .s_addr(AW)) bus();
    cache_arbiter #(.s_line(LW), .s_addr(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (!(bus.i_read && bus.i_write)) else $error("illegal: i_read and i_write together");
            assert (!(bus.d_read && bus.d_write)) else $error("illegal: d_read and d_write together");
        end
    end

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    logic [LW-1:0] mem_m [logic [AW-1:0]];

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic clear_inputs();
        bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_address = '0; bus.i_wdata = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    endtask

    // Leaves the caller at posedge+1 of the first post-reset cycle, ready to drive cycle 0.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst mem_read", bus.mem_read, 1'b0);
        chk("rst mem_write", bus.mem_write, 1'b0);
        chk("rst mem_address", bus.mem_address, '0);
        chk("rst mem_wdata", bus.mem_wdata, '0);
        chk("rst resps", {bus.i_resp, bus.d_resp}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [LW-1:0] pat_a5;
    logic [LW-1:0] pat_w;
    bit            busy;
    int            owner, last, age, lat;
    txn_t          exp_t;
    bit            pres [2];
    txn_t          cur [2];

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_w  = {8{32'h1234_5678}};

        // Single I read answered in cycle 5.
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 32'h0000_0060;
        for (int c = 0; c <= 6; c++) begin
            bus.mem_resp  = (c == 5);
            bus.mem_rdata = (c == 5) ? pat_a5 : rand_line();
            if (c == 6) bus.i_read = 1'b0;
            @(negedge clk);
            chk("t1 mem_read", bus.mem_read, (c >= 1 && c <= 5));
            if (c >= 1 && c <= 5) chk("t1 mem_address", bus.mem_address, 32'h60);
            chk("t1 i_resp", bus.i_resp, (c == 5));
            chk("t1 d_resp", bus.d_resp, 1'b0);
            if (c == 5) chk("t1 i_rdata", bus.i_rdata, pat_a5);
            @(posedge clk); #1;
        end
        bus.mem_resp = 1'b0;

        // D write-back with requester data changed mid-transaction.
        bus.d_write = 1'b1; bus.d_address = 32'h0000_0100; bus.d_wdata = pat_w;
        for (int c = 0; c <= 5; c++) begin
            if (c == 2) begin bus.d_wdata = ~pat_w; bus.d_address = 32'h0000_0AE0; end
            if (c == 5) bus.d_write = 1'b0;
            bus.mem_resp = (c == 4);
            @(negedge clk);
            chk("t2 mem_write", bus.mem_write, (c >= 1 && c <= 4));
            chk("t2 mem_read", bus.mem_read, 1'b0);
            if (c >= 1 && c <= 4) begin
                chk("t2 mem_wdata", bus.mem_wdata, pat_w);
                chk("t2 mem_address", bus.mem_address, 32'h100);
            end
            chk("t2 d_resp", bus.d_resp, (c == 4));
            chk("t2 i_resp", bus.i_resp, 1'b0);
            @(posedge clk); #1;
        end
        bus.mem_resp = 1'b0;

        // Both caches requesting continuously from reset: I, D, I, D with a bubble between.
        begin
            int   seen = 0;
            int   hi = 0;
            logic prev = 1'b0;
            logic resp_last = 1'b0;
            do_reset();
            bus.i_read = 1'b1; bus.i_address = 32'h0000_0080;
            bus.d_read = 1'b1; bus.d_address = 32'h0000_0340;
            for (int c = 0; c < 60 && seen < 4; c++) begin
                bus.mem_resp = (hi == 2);
                @(negedge clk);
                if (resp_last) chk("t3 bubble", bus.mem_read, 1'b0);
                if (bus.mem_read && !prev) begin
                    chk("t3 order", bus.mem_address, (seen % 2) ? 32'h340 : 32'h80);
                    seen++;
                end
                if (bus.mem_resp)
                    chk("t3 resp", {bus.i_resp, bus.d_resp}, ((seen - 1) % 2) ? 2'b01 : 2'b10);
                resp_last = bus.mem_resp;
                hi   = bus.mem_resp ? 0 : (bus.mem_read ? hi + 1 : 0);
                prev = bus.mem_read;
                @(posedge clk); #1;
            end
            chk("t3 grant count", seen, 4);
        end

        // Reset in cycle 3 of a D read; a late mem_resp must be ignored.
        do_reset();
        bus.d_read = 1'b1; bus.d_address = 32'h0000_0200;
        for (int c = 0; c <= 7; c++) begin
            if (c == 3) begin rst = 1'b1; bus.d_read = 1'b0; end
            if (c == 4) rst = 1'b0;
            bus.mem_resp = (c == 6);
            @(negedge clk);
            chk("t4 mem_read", bus.mem_read, (c >= 1 && c <= 3));
            if (c >= 4) chk("t4 resps", {bus.i_resp, bus.d_resp}, 2'b00);
            @(posedge clk); #1;
        end

        // Stray response in IDLE, then a normal grant proves the FSM stayed idle.
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("t5 stray resps", {bus.i_resp, bus.d_resp}, 2'b00);
        @(posedge clk); #1;
        bus.mem_resp = 1'b0; bus.i_read = 1'b1; bus.i_address = 32'h0000_0040;
        @(negedge clk);
        chk("t5 idle op", {bus.mem_read, bus.mem_write}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5 grant read", bus.mem_read, 1'b1);
        chk("t5 grant addr", bus.mem_address, 32'h40);
        @(posedge clk); #1;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("t5 i_resp", bus.i_resp, 1'b1);
        @(posedge clk); #1;
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;

        // Random traffic against a transaction-level model of caches and memory.
        do_reset();
        busy = 1'b0; last = 1; owner = 0; age = 0; lat = 0;
        pres[0] = 1'b0; pres[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pres[s] && $urandom_range(0, 2) == 0) begin
                    cur[s].wr    = ($urandom_range(0, 3) == 0);
                    cur[s].addr  = AW'($urandom_range(0, 15)) << 5;
                    cur[s].wdata = rand_line();
                    pres[s]      = 1'b1;
                end
            end
            bus.i_read    = pres[0] && !cur[0].wr;
            bus.i_write   = pres[0] && cur[0].wr;
            bus.i_address = (busy && owner == 0) ? $urandom() : cur[0].addr;
            bus.i_wdata   = (busy && owner == 0) ? rand_line() : cur[0].wdata;
            bus.d_read    = pres[1] && !cur[1].wr;
            bus.d_write   = pres[1] && cur[1].wr;
            bus.d_address = (busy && owner == 1) ? $urandom() : cur[1].addr;
            bus.d_wdata   = (busy && owner == 1) ? rand_line() : cur[1].wdata;
            if (busy && age >= lat) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = exp_t.wr ? rand_line() : mem_line(exp_t.addr);
            end else begin
                bus.mem_resp  = !busy && ($urandom_range(0, 7) == 0);
                bus.mem_rdata = rand_line();
            end
            @(negedge clk);
            if (busy) begin
                chk("rnd mem_read", bus.mem_read, !exp_t.wr);
                chk("rnd mem_write", bus.mem_write, exp_t.wr);
                chk("rnd mem_address", bus.mem_address, exp_t.addr);
                if (exp_t.wr) chk("rnd mem_wdata", bus.mem_wdata, exp_t.wdata);
                if (bus.mem_resp) begin
                    chk("rnd i_resp", bus.i_resp, (owner == 0));
                    chk("rnd d_resp", bus.d_resp, (owner == 1));
                    if (!exp_t.wr)
                        chk("rnd rdata", (owner == 0) ? bus.i_rdata : bus.d_rdata, mem_line(exp_t.addr));
                end else begin
                    chk("rnd busy resps", {bus.i_resp, bus.d_resp}, 2'b00);
                end
            end else begin
                chk("rnd idle op", {bus.mem_read, bus.mem_write}, 2'b00);
                chk("rnd idle resps", {bus.i_resp, bus.d_resp}, 2'b00);
            end
            if (busy) begin
                if (bus.mem_resp) begin
                    busy = 1'b0;
                    if (exp_t.wr) mem_m[exp_t.addr] = exp_t.wdata;
                    pres[owner] = 1'b0;
                end else begin
                    age++;
                end
            end else if (pres[0] || pres[1]) begin
                owner = (pres[0] && pres[1]) ? 1 - last : (pres[0] ? 0 : 1);
                last  = owner;
                exp_t = cur[owner];
                busy  = 1'b1;
                age   = 0;
                lat   = $urandom_range(0, 4);
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single 256-bit physical-memory line port between the instruction cache and the data cache. Each cache issues whole-line reads or write-backs on its own line-side port. The arbiter grants one requester at a time, latches its request, and drives the memory port from those latched values. It routes the memory response back to the granted cache only.

## Interface
**Parameters**
- s_line, 256, line width in bits (data buses)
- s_addr, 32, address width in bits

**Ports**
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_read  in  1  I-cache line read request; held until i_resp
- i_write  in  1  I-cache line write request; tied 0 in practice but fully supported
- i_address  in  s_addr  I-cache line address, 32-byte aligned
- i_wdata  in  s_line  I-cache write line
- i_rdata  out  s_line  read line to I-cache
- i_resp  out  1  one-cycle completion to I-cache
- d_read, d_write, d_address, d_wdata, d_rdata, d_resp: same as i_*, for the D-cache
- mem_read  out  1  memory line read; held until mem_resp
- mem_write  out  1  memory line write; held until mem_resp
- mem_address  out  s_addr  latched address of the granted request
- mem_wdata  out  s_line  latched write line of the granted request
- mem_rdata  in  s_line  memory read line
- mem_resp  in  1  one-cycle memory completion

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. State, last_grant and the latch registers (op, address, wdata) are all registered.
- **IDLE**
  - Pending means a requester has read or write asserted.
  - Only I pending: go to SERVE_I. Only D pending: go to SERVE_D.
  - Both pending: grant the requester that is not last_grant, and update last_grant.
  - On the grant edge, latch that requester's address, wdata and op.
  - If a requester asserts read and write together, write wins. This is an illegal input; the bench asserts on it.
- **SERVE_I / SERVE_D**
  - mem_read or mem_write equals the latched op; mem_address and mem_wdata equal the latched values.
  - Requester inputs are ignored after the grant edge.
  - When mem_resp=1, assert <x>_resp=1 combinationally in the same cycle to the granted side only, and return to IDLE on that edge.
- **Read data:** i_rdata and d_rdata both carry mem_rdata continuously. Only the matching resp qualifies the data.
- **Stray responses:** mem_resp in IDLE is ignored; no resp is generated.
- **Reset values:**
  - State is IDLE and last_grant is D, so the first tie goes to I.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
  - i_resp=0, d_resp=0.
- **Reset mid-transaction:** the FSM returns to IDLE and the memory request drops the next cycle. Any later mem_resp for the aborted request is ignored.

## Timing
- **Request to memory:**
  - Cycle 0: request seen in IDLE.
  - Edge ending cycle 0: grant.
  - Cycle 1: mem_read/mem_write high.
- **Memory response:**
  - mem_resp in cycle k gives <x>_resp in cycle k with zero added latency.
  - mem_read/mem_write are 0 in cycle k+1 (IDLE).
- **Back-to-back:** one IDLE bubble cycle between consecutive memory transactions. The minimum arbiter overhead is 1 cycle before each transaction.
- **Requester contract:** the requester deasserts read/write in the cycle after its resp, unless it issues a new request. A request still high in IDLE at k+1 is treated as new.
- **Fairness:** with both caches continuously requesting, grants strictly alternate. Neither side waits more than one other transaction.
- **Bus stability:** mem_address, mem_wdata and the op are stable from the grant edge until mem_resp, regardless of requester inputs.
- **Outputs:** all memory-side outputs are register-driven. resp outputs are combinational from mem_resp and state.

## Test plan
- **Single I read:** i_read=1, i_address=0x0000_0060 in cycle 0; memory responds in cycle 5 with rdata=0xA5…A5.
  - Required: mem_read=1 and mem_address=0x60 in cycles 1–5.
  - i_resp=1 only in cycle 5, with i_rdata=0xA5…A5; d_resp stays 0.
- **D write-back:** d_write=1, d_address=0x100, d_wdata=0x1234…; d_wdata changed in cycle 2.
  - Required: mem_write=1 and mem_wdata=0x1234… unchanged until mem_resp; d_resp on the resp cycle.
- **Simultaneous requests from reset:** i_read and d_read both asserted in cycle 0.
  - Required: I granted first (mem_address=i_address). After i_resp, one IDLE cycle, then D granted.
  - With both held continuously: grant order I, D, I, D.
- **Reset mid-transaction:** rst=1 in cycle 3 of a D read.
  - Required: mem_read=0 from cycle 4.
  - mem_resp=1 in cycle 6 produces no i_resp and no d_resp.
- **Stray response:** mem_resp=1 while in IDLE with no requests.
  - Required: i_resp=d_resp=0 and the state stays IDLE.
